// File: rtl/mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter for the single memory port of the npc core.
// Optional macro MEM_ARB_RR_EN selects round-robin tie-break; default is LSU-first fixed priority.
module mem_arbiter #(
  parameter int                ADDR_W  = 64,
  parameter int                DATA_W  = 64,
  parameter int                WDT_W   = 4,
  parameter logic [WDT_W-1:0]  IFU_WDT = WDT_W'(4'b0100)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ifu_req_valid,
  input  logic [ADDR_W-1:0] ifu_req_addr,
  output logic              ifu_req_ready,
  output logic              ifu_resp_valid,
  output logic [31:0]       ifu_resp_data,
  input  logic              lsu_req_valid,
  input  logic              lsu_req_wen,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic [DATA_W-1:0] lsu_req_wdata,
  input  logic [WDT_W-1:0]  lsu_req_wdt,
  output logic              lsu_req_ready,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_resp_data,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [WDT_W-1:0]  wdt_op,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD_IF, RD_LS, WR_ACK} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic [WDT_W-1:0]  lat_wdt_q, lat_wdt_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_ifu, grant_lsu;

  // Pre-gating output values; everything is forced low while rst_n is low.
  logic              ifu_ready_c, ifu_rvld_c, lsu_ready_c, lsu_rvld_c;
  logic [31:0]       ifu_rdata_c;
  logic [DATA_W-1:0] lsu_rdata_c, wdata_c;
  logic [ADDR_W-1:0] raddr_c, waddr_c;
  logic              wen_c, ren_c;
  logic [WDT_W-1:0]  wdt_c;

  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state_q == IDLE) begin
      if (ifu_req_valid && lsu_req_valid) begin
`ifdef MEM_ARB_RR_EN
        grant_ifu = last_grant_q;
        grant_lsu = !last_grant_q;
`else
        grant_lsu = 1'b1;
`endif
      end else begin
        grant_ifu = ifu_req_valid;
        grant_lsu = lsu_req_valid;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    lat_addr_d   = lat_addr_q;
    lat_wdt_d    = lat_wdt_q;
    last_grant_d = last_grant_q;
    ifu_ready_c  = 1'b0;
    ifu_rvld_c   = 1'b0;
    ifu_rdata_c  = '0;
    lsu_ready_c  = 1'b0;
    lsu_rvld_c   = 1'b0;
    lsu_rdata_c  = '0;
    raddr_c      = lat_addr_q;
    wdt_c        = lat_wdt_q;
    waddr_c      = '0;
    wdata_c      = '0;
    wen_c        = 1'b0;
    ren_c        = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_ifu) begin
          ifu_ready_c  = 1'b1;
          ren_c        = 1'b1;
          raddr_c      = ifu_req_addr;
          wdt_c        = IFU_WDT;
          lat_addr_d   = ifu_req_addr;
          lat_wdt_d    = IFU_WDT;
          last_grant_d = 1'b0;
          state_d      = RD_IF;
        end else if (grant_lsu) begin
          lsu_ready_c  = 1'b1;
          wdt_c        = lsu_req_wdt;
          last_grant_d = 1'b1;
          if (lsu_req_wen) begin
            // Memory commits on the negedge of this cycle; only an ack follows.
            wen_c   = 1'b1;
            waddr_c = lsu_req_addr;
            wdata_c = lsu_req_wdata;
            state_d = WR_ACK;
          end else begin
            ren_c      = 1'b1;
            raddr_c    = lsu_req_addr;
            lat_addr_d = lsu_req_addr;
            lat_wdt_d  = lsu_req_wdt;
            state_d    = RD_LS;
          end
        end
      end
      RD_IF: begin
        ifu_rvld_c  = 1'b1;
        ifu_rdata_c = mem_rdata[31:0];
        state_d     = IDLE;
      end
      RD_LS: begin
        lsu_rvld_c  = 1'b1;
        lsu_rdata_c = mem_rdata;
        state_d     = IDLE;
      end
      WR_ACK: begin
        lsu_rvld_c = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lat_addr_q   <= '0;
      lat_wdt_q    <= '0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      lat_addr_q   <= lat_addr_d;
      lat_wdt_q    <= lat_wdt_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign ifu_req_ready  = rst_n & ifu_ready_c;
  assign ifu_resp_valid = rst_n & ifu_rvld_c;
  assign ifu_resp_data  = rst_n ? ifu_rdata_c : '0;
  assign lsu_req_ready  = rst_n & lsu_ready_c;
  assign lsu_resp_valid = rst_n & lsu_rvld_c;
  assign lsu_resp_data  = rst_n ? lsu_rdata_c : '0;
  assign mem_raddr      = rst_n ? raddr_c : '0;
  assign mem_waddr      = rst_n ? waddr_c : '0;
  assign mem_wdata      = rst_n ? wdata_c : '0;
  assign mem_wen        = rst_n & wen_c;
  assign mem_ren        = rst_n & ren_c;
  assign wdt_op         = rst_n ? wdt_c : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a little-endian registered-read memory model and response scoreboard.
module tb_mem_arbiter;
  localparam logic [3:0] W8 = 4'b0001, W16 = 4'b0010, W32 = 4'b0100, W64 = 4'b1000;

  logic        clk = 1'b0, rst_n;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [63:0] ifu_req_addr;
  logic [31:0] ifu_resp_data;
  logic        lsu_req_valid, lsu_req_wen, lsu_req_ready, lsu_resp_valid;
  logic [63:0] lsu_req_addr, lsu_req_wdata, lsu_resp_data;
  logic [3:0]  lsu_req_wdt, wdt_op;
  logic [63:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
  logic        mem_wen, mem_ren;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr), .ifu_req_ready(ifu_req_ready),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_wen(lsu_req_wen), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wdata(lsu_req_wdata), .lsu_req_wdt(lsu_req_wdt), .lsu_req_ready(lsu_req_ready),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wen(mem_wen), .mem_ren(mem_ren), .wdt_op(wdt_op), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] wmask(input logic [3:0] w);
    case (w)
      W8:      return 64'hFF;
      W16:     return 64'hFFFF;
      W32:     return 64'hFFFF_FFFF;
      W64:     return '1;
      default: return '0;
    endcase
  endfunction

  // Memory: doubleword registered on posedge when mem_ren, lane mux uses the live address/width.
  logic [63:0] mem [0:63];
  logic [63:0] rd_dw = '0;
  always @(posedge clk) if (mem_ren) rd_dw <= mem[mem_raddr[8:3]];
  assign mem_rdata = (rd_dw >> {mem_raddr[2:0], 3'b000}) & wmask(wdt_op);

  always @(negedge clk) begin
    if (!rst_n) begin
      mem[0]  <= 64'h0010_0093_0000_0013;
      mem[2]  <= 64'h1122_3344_5566_7788;
      mem[32] <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else if (mem_wen) begin
      mem[mem_waddr[8:3]] <= (mem[mem_waddr[8:3]] & ~(wmask(wdt_op) << {mem_waddr[2:0], 3'b000}))
                           | ((mem_wdata & wmask(wdt_op)) << {mem_waddr[2:0], 3'b000});
    end
  end

  typedef struct { bit ifu; logic [63:0] data; } exp_t;
  exp_t exp_q[$];
  int vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input bit ifu, input logic [63:0] d);
    exp_t e;
    e.ifu = ifu; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic expect_resp(input string tag);
    exp_t e;
    chk({tag, "_sb"}, 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    chk({tag, "_vld"}, 64'(e.ifu ? ifu_resp_valid : lsu_resp_valid), 64'd1);
    chk({tag, "_other"}, 64'(e.ifu ? lsu_resp_valid : ifu_resp_valid), 64'd0);
    chk({tag, "_data"}, e.ifu ? 64'(ifu_resp_data) : lsu_resp_data, e.data);
    chk({tag, "_excl"}, 64'(mem_wen & mem_ren), 64'd0);
  endtask

  task automatic lsu_access(input string tag, input bit wen, input logic [63:0] a,
                            input logic [63:0] wd, input logic [3:0] w, input logic [63:0] exp);
    step();
    lsu_req_valid = 1'b1; lsu_req_wen = wen; lsu_req_addr = a; lsu_req_wdata = wd; lsu_req_wdt = w;
    @(negedge clk);
    chk({tag, "_ready"}, 64'(lsu_req_ready), 64'd1);
    chk({tag, "_wen"}, 64'(mem_wen), 64'(wen));
    chk({tag, "_ren"}, 64'(mem_ren), 64'(!wen));
    chk({tag, "_wdt"}, 64'(wdt_op), 64'(w));
    if (wen) begin
      chk({tag, "_waddr"}, mem_waddr, a);
      chk({tag, "_wdata"}, mem_wdata, wd);
    end else begin
      chk({tag, "_raddr"}, mem_raddr, a);
    end
    push(1'b0, exp);
    step();
    lsu_req_valid = 1'b0; lsu_req_wen = 1'b0;
    @(negedge clk);
    expect_resp(tag);
    if (!wen) chk({tag, "_wdt_hold"}, 64'(wdt_op), 64'(w));
  endtask

  initial begin
    bit exp_ifu;
    rst_n = 1'b0;
    ifu_req_valid = 1'b1; ifu_req_addr = 64'h8000_0004;
    lsu_req_valid = 1'b1; lsu_req_wen = 1'b1; lsu_req_addr = 64'h8000_0100;
    lsu_req_wdata = 64'h1234; lsu_req_wdt = W32;
    @(negedge clk); @(negedge clk);
    chk("rst_ifu_ready", 64'(ifu_req_ready), 64'd0);
    chk("rst_lsu_ready", 64'(lsu_req_ready), 64'd0);
    chk("rst_wen", 64'(mem_wen), 64'd0);
    chk("rst_ren", 64'(mem_ren), 64'd0);
    chk("rst_waddr", mem_waddr, 64'd0);
    chk("rst_wdt", 64'(wdt_op), 64'd0);

    // Single fetch straight out of reset.
    step();
    rst_n = 1'b1; lsu_req_valid = 1'b0; lsu_req_wen = 1'b0;
    @(negedge clk);
    chk("f_ready", 64'(ifu_req_ready), 64'd1);
    chk("f_ren", 64'(mem_ren), 64'd1);
    chk("f_raddr", mem_raddr, 64'h8000_0004);
    chk("f_wdt", 64'(wdt_op), 64'(W32));
    push(1'b1, 64'h0010_0093);
    step();
    ifu_req_valid = 1'b0;
    @(negedge clk);
    expect_resp("fetch");
    chk("f_raddr_hold", mem_raddr, 64'h8000_0004);
    chk("f_ren_off", 64'(mem_ren), 64'd0);
    step();
    @(negedge clk);
    chk("idle_ren", 64'(mem_ren), 64'd0);
    chk("idle_resp", 64'(ifu_resp_valid | lsu_resp_valid), 64'd0);
    chk("idle_raddr_lat", mem_raddr, 64'h8000_0004);

    lsu_access("ldb12", 1'b0, 64'h8000_0012, 64'd0, W8, 64'h66);
    lsu_access("ldb13", 1'b0, 64'h8000_0013, 64'd0, W8, 64'h55);
    lsu_access("st32", 1'b1, 64'h8000_0100, 64'hDEAD_BEEF, W32, 64'd0);
    lsu_access("ld32", 1'b0, 64'h8000_0100, 64'd0, W32, 64'hDEAD_BEEF);
    lsu_access("ld64", 1'b0, 64'h8000_0100, 64'd0, W64, 64'hFFFF_FFFF_DEAD_BEEF);

    // Both requesters valid for six cycles; last grant so far was the LSU.
    step();
    ifu_req_valid = 1'b1; ifu_req_addr = 64'h8000_0004;
    lsu_req_valid = 1'b1; lsu_req_wen = 1'b0; lsu_req_addr = 64'h8000_0012; lsu_req_wdt = W8;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c % 2 == 0) begin
`ifdef MEM_ARB_RR_EN
        exp_ifu = (c != 2);
`else
        exp_ifu = 1'b0;
`endif
        chk($sformatf("tie%0d_ifu_ready", c), 64'(ifu_req_ready), 64'(exp_ifu));
        chk($sformatf("tie%0d_lsu_ready", c), 64'(lsu_req_ready), 64'(!exp_ifu));
        push(exp_ifu, exp_ifu ? 64'h0010_0093 : 64'h66);
      end else begin
        chk($sformatf("tie%0d_no_grant", c), 64'(ifu_req_ready | lsu_req_ready), 64'd0);
        expect_resp($sformatf("tie%0d", c));
      end
      step();
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;

    // IFU request arriving during RD_LS waits for the next IDLE.
    lsu_req_valid = 1'b1; lsu_req_addr = 64'h8000_0013; lsu_req_wdt = W8;
    @(negedge clk);
    chk("rdls_lsu_ready", 64'(lsu_req_ready), 64'd1);
    push(1'b0, 64'h55);
    step();
    lsu_req_valid = 1'b0; ifu_req_valid = 1'b1; ifu_req_addr = 64'h8000_0004;
    @(negedge clk);
    chk("rdls_ifu_wait", 64'(ifu_req_ready), 64'd0);
    expect_resp("rdls");
    step();
    @(negedge clk);
    chk("rdls_ifu_grant", 64'(ifu_req_ready), 64'd1);
    push(1'b1, 64'h0010_0093);
    step();
    ifu_req_valid = 1'b0;
    @(negedge clk);
    expect_resp("rdls_fetch");

    // Reset during RD_IF abandons the fetch.
    step();
    ifu_req_valid = 1'b1; ifu_req_addr = 64'h8000_0000;
    @(negedge clk);
    chk("mrst_grant", 64'(ifu_req_ready), 64'd1);
    step();
    ifu_req_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_no_resp", 64'(ifu_resp_valid), 64'd0);
    chk("mrst_raddr", mem_raddr, 64'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_ifu_resp", 64'(ifu_resp_valid), 64'd0);
    chk("post_lsu_resp", 64'(lsu_resp_valid), 64'd0);
    chk("post_raddr", mem_raddr, 64'd0);
    chk("post_wdt", 64'(wdt_op), 64'd0);
    chk("post_ren", 64'(mem_ren), 64'd0);
    step();
    @(negedge clk);
    chk("post2_ifu_resp", 64'(ifu_resp_valid), 64'd0);
    chk("sb_drain", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
